// File: rtl/sfifo_pkg.sv
// Shared definitions for the sfifo consumer blocks: default byte width,
// packer FSM state encoding, and a helper sizing the lane index.
package sfifo_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } pack_state_e;

  // Bits needed to index one of `lanes` byte lanes (at least 1).
  function automatic int lane_idx_width(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/sfifo_word_packer.sv
// sfifo_word_packer
// Pops bytes from the synchronous byte FIFO through its active-low read
// strobe, packs WORD_BYTES of them into one word (byte 0 in the low lane)
// and offers each word on a valid/ready port. A flush request pushes out
// whatever partial word is held, with unused lanes zeroed.
//
//  state | meaning
//  FILL  | normal packing; reads issued while room remains in the word
//  FLUSH | no new reads; wait for the in-flight byte, then emit partial word
module sfifo_word_packer
  import sfifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int WORD_BYTES = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              fifo_data,
  input  logic                               fifo_empty,
  output logic                               fifo_read_n,
  input  logic                               flush,
  output logic [DATA_WIDTH*WORD_BYTES-1:0]   word_data,
  output logic [$clog2(WORD_BYTES+1)-1:0]    word_bytes,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic                               busy
);

  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam int IW = lane_idx_width(WORD_BYTES);

  localparam logic [0:0] S_FILL  = FILL;
  localparam logic [0:0] S_FLUSH = FLUSH;

  logic [0:0]                     state;
  logic [CW-1:0]                  count;
  logic                           inflight;
  logic [DATA_WIDTH-1:0]          lanes [WORD_BYTES];
  logic [DATA_WIDTH*WORD_BYTES-1:0] packed_word;
  logic [CW-1:0]                  fill_lvl;
  logic                           out_free;
  logic                           rd_en;
  logic                           xfer_full;
  logic                           xfer_flush;
  logic                           xfer;

  // Bytes already held plus the one that will land this cycle; reads stop
  // once a full word is accounted for so nothing is over-fetched.
  assign fill_lvl = count + CW'(inflight);
  assign out_free = ~word_valid | word_ready;

  // Reset gates the strobe so no byte is popped only to be discarded.
  assign rd_en = ~reset & ~fifo_empty & (state == S_FILL) &
                 (fill_lvl < CW'(WORD_BYTES));
  assign fifo_read_n = ~rd_en;

  // A full word never coincides with an in-flight byte, and a flush move
  // waits for the in-flight byte, so capture and transfer never collide.
  assign xfer_full  = (state == S_FILL) && (count == CW'(WORD_BYTES)) && out_free;
  assign xfer_flush = (state == S_FLUSH) && !inflight && (count != '0) && out_free;
  assign xfer       = xfer_full | xfer_flush;

  assign busy = (count != '0) | inflight | word_valid;

  // Assemble the outgoing word, zeroing lanes not yet filled.
  always_comb begin
    packed_word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (CW'(i) < count) packed_word[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
    end
  end

  // Byte capture into the pack register; lanes past count are masked off.
  always_ff @(posedge clock) begin
    if (inflight && !reset) lanes[count[IW-1:0]] <= fifo_data;
  end

  // Pack count, read-in-flight flag and FILL/FLUSH sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FILL;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (xfer)          count <= '0;
      else if (inflight) count <= count + 1'b1;

      case (state)
        S_FILL: begin
          if (!xfer_full && flush && (fill_lvl != '0)) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (!inflight && ((count == '0) || out_free)) state <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
    end
  end

  // Output register: load on transfer, hold until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_valid <= 1'b0;
      word_data  <= '0;
      word_bytes <= '0;
    end else if (xfer) begin
      word_valid <= 1'b1;
      word_data  <= packed_word;
      word_bytes <= count;
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sfifo_word_packer.sv
// Bench for sfifo_word_packer: a simple FIFO model feeds the packer,
// directed scenarios check specific words, and a randomized run checks the
// accepted byte stream against the pushed byte stream.
module tb_sfifo_word_packer;

  localparam int DW = 8;
  localparam int WB = 4;
  localparam int BW = $clog2(WB + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_read_n;
  logic          flush;
  logic [DW*WB-1:0] word_data;
  logic [BW-1:0] word_bytes;
  logic          word_valid;
  logic          word_ready;
  logic          busy;

  sfifo_word_packer #(.DATA_WIDTH(DW), .WORD_BYTES(WB)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_read_n(fifo_read_n),
    .flush      (flush),
    .word_data  (word_data),
    .word_bytes (word_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // FIFO model: registered data_out, one pop per low read strobe.
  logic [DW-1:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (!fifo_read_n && !fifo_empty) begin
      fifo_data <= mem[rd_ptr & 255];
      rd_ptr    <= rd_ptr + 1;
      pop_cnt   <= pop_cnt + 1;
    end
  end

  task automatic push(input logic [DW-1:0] b);
    mem[wr_ptr & 255] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  logic [BW+DW*WB-1:0] got_q [$];
  logic [DW-1:0] got_stream [$];
  logic [DW-1:0] exp_stream [$];
  bit collect = 0;
  bit flush_seen = 0;
  bit stall_prev = 0;
  logic [DW*WB-1:0] data_prev;
  logic [BW-1:0] bytes_prev;
  int rd_low_cnt = 0;
  int rd_empty_viol = 0;
  int stall_viol = 0;
  int lane_viol = 0;
  int partial_viol = 0;

  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (!fifo_read_n) rd_low_cnt++;
      if (!fifo_read_n && fifo_empty) rd_empty_viol++;
      if (stall_prev && (!word_valid || word_data !== data_prev || word_bytes !== bytes_prev))
        stall_viol++;
      stall_prev = word_valid && !word_ready;
      data_prev  = word_data;
      bytes_prev = word_bytes;
      if (word_valid && word_ready) begin
        got_q.push_back({word_bytes, word_data});
        if (collect) begin
          if (word_bytes == 0 || word_bytes > WB) lane_viol++;
          for (int i = 0; i < WB; i++) begin
            if (i < int'(word_bytes)) got_stream.push_back(word_data[i*DW +: DW]);
            else if (word_data[i*DW +: DW] != 0) lane_viol++;
          end
          if (word_bytes < WB) begin
            if (!flush_seen) partial_viol++;
            flush_seen = 0;
          end
        end
      end
      if (collect && flush) flush_seen = 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [DW*WB-1:0] d, input logic [BW-1:0] b);
    int budget = 60;
    logic [BW+DW*WB-1:0] w;
    while (got_q.size() == 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (got_q.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      w = got_q.pop_front();
      chk({tag, "_data"}, w[DW*WB-1:0], d);
      chk({tag, "_bytes"}, w[BW+DW*WB-1:DW*WB], b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got 0 want 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    logic [DW-1:0] b;
    reset = 1'b1;
    flush = 1'b0;
    word_ready = 1'b1;

    // Test 1: preload 0x01..0x08 during reset.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    tick(2);
    chk("rst_read_n", fifo_read_n, 1);
    chk("rst_valid", word_valid, 0);
    chk("rst_data", word_data, 0);
    chk("rst_bytes", word_bytes, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    expect_word("t1_w0", 32'h04030201, 4);
    expect_word("t1_w1", 32'h08070605, 4);

    // Test 2: three bytes then flush.
    tick(5);
    push(8'h11); push(8'h22); push(8'h33);
    tick(8);
    chk("t2_no_early", got_q.size(), 0);
    flush = 1'b1; tick(1); flush = 1'b0;
    expect_word("t2_part", 32'h00332211, 3);
    base = rd_low_cnt;
    tick(5);
    chk("t2_no_read", rd_low_cnt - base, 0);

    // Test 3: output stalled with 12 bytes queued.
    word_ready = 1'b0;
    base = pop_cnt;
    for (int i = 0; i < 12; i++) push(DW'(8'h31 + i));
    tick(30);
    chk("t3_pops", pop_cnt - base, 8);
    chk("t3_valid", word_valid, 1);
    chk("t3_data", word_data, 32'h34333231);
    chk("t3_busy", busy, 1);
    word_ready = 1'b1;
    expect_word("t3_w0", 32'h34333231, 4);
    expect_word("t3_w1", 32'h38373635, 4);
    expect_word("t3_w2", 32'h3C3B3A39, 4);
    chk("t3_stall_stable", stall_viol, 0);

    // Test 4: single byte drains the FIFO with the read in flight.
    tick(3);
    base = rd_low_cnt;
    push(8'hA5);
    tick(6);
    chk("t4_one_read", rd_low_cnt - base, 1);
    chk("t4_no_word", got_q.size(), 0);
    flush = 1'b1; tick(1); flush = 1'b0;
    expect_word("t4_part", 32'h000000A5, 1);
    chk("t4_rd_empty", rd_empty_viol, 0);

    // Test 5: flush with nothing held, then flush during the in-flight cycle.
    tick(3);
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(5);
    chk("t5_no_word", got_q.size(), 0);
    chk("t5_idle", busy, 0);
    push(8'h5A);
    tick(1);
    flush = 1'b1; tick(1); flush = 1'b0;
    expect_word("t5_part", 32'h0000005A, 1);

    // Test 6: reset with count=2 and a word held.
    word_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'(8'hC1 + i));
    tick(15);
    chk("t6_held", word_valid, 1);
    reset = 1'b1;
    tick(1);
    chk("t6_valid", word_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_read_n", fifo_read_n, 1);
    reset = 1'b0;
    word_ready = 1'b1;
    tick(2);
    chk("t6_empty_out", got_q.size(), 0);
    for (int i = 1; i <= 4; i++) push(DW'(i));
    expect_word("t6_w", 32'h04030201, 4);

    // Randomized traffic: stream integrity against pushed bytes.
    tick(5);
    collect = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 40 && (wr_ptr - rd_ptr) < 200) begin
        b = DW'($urandom);
        push(b);
        exp_stream.push_back(b);
      end
      word_ready = ($urandom_range(0, 99) < 60);
      flush = ($urandom_range(0, 99) < 3);
      tick(1);
    end
    flush = 1'b0;
    word_ready = 1'b1;
    tick(20);
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(20);
    collect = 0;
    chk("rnd_count", got_stream.size(), exp_stream.size());
    for (int i = 0; i < exp_stream.size(); i++) begin
      if (i < got_stream.size()) chk($sformatf("rnd_byte%0d", i), got_stream[i], exp_stream[i]);
    end
    chk("rnd_lanes", lane_viol, 0);
    chk("rnd_partial", partial_viol, 0);
    chk("rnd_stall", stall_viol, 0);
    chk("rnd_rd_empty", rd_empty_viol, 0);
    chk("rnd_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
